// File: rtl/mem_bist_pkg.sv
// Shared memory-BIST definitions: FSM encoding, access phase and the expected-word helper.
// Used by the BIST sequencer and its read-check pipe; holds no logic of its own.
package mem_bist_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WR0    = 3'd1;
  localparam logic [2:0] ST_RD0    = 3'd2;
  localparam logic [2:0] ST_DRAIN0 = 3'd3;
  localparam logic [2:0] ST_WR1    = 3'd4;
  localparam logic [2:0] ST_RD1    = 3'd5;
  localparam logic [2:0] ST_DRAIN1 = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    WR0    = ST_WR0,
    RD0    = ST_RD0,
    DRAIN0 = ST_DRAIN0,
    WR1    = ST_WR1,
    RD1    = ST_RD1,
    DRAIN1 = ST_DRAIN1,
    DONE   = ST_DONE
  } state_t;

  typedef enum logic {
    PASS_WR = 1'b0,
    PASS_RD = 1'b1
  } phase_t;

  // Wide enough for any practical word/address width; callers zero-extend in and slice out,
  // which also truncates the address when it is wider than the data word.
  localparam int EXP_W = 64;

  function automatic logic [EXP_W-1:0] exp_word(input logic [EXP_W-1:0] pattern,
                                                input logic [EXP_W-1:0] addr,
                                                input logic             inv);
    logic [EXP_W-1:0] w;
    w = pattern ^ addr;
    return inv ? ~w : w;
  endfunction

endpackage

// File: rtl/mem_bist_chk.sv
// Read-check pipe: carries {valid, expected word, address} for READ_LATENCY cycles per read.
// Compares r_data against the head every cycle; never stalls, first-fail address and count held until clr.
module mem_bist_chk #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push_vld,
  input  logic [DATA_WIDTH-1:0] push_dat,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  mismatch,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [ADDR_WIDTH+1:0] err_count
);
  import mem_bist_pkg::*;

  typedef struct packed {
    logic                  vld;
    logic [DATA_WIDTH-1:0] dat;
    logic [ADDR_WIDTH-1:0] addr;
  } ent_t;

  localparam logic [ADDR_WIDTH+1:0] CNT_ONE = (ADDR_WIDTH+2)'(1);

  ent_t pipe_q [READ_LATENCY];
  ent_t head;

  assign head     = pipe_q[READ_LATENCY-1];
  assign mismatch = head.vld && (r_data != head.dat);

  // Entry pushed with a read reaches the head exactly when that read's data is on r_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{vld: push_vld, dat: push_dat, addr: push_addr};
      for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_count <= '0;
      err_addr  <= '0;
    end else if (mismatch) begin
      err_count <= err_count + CNT_ONE;
      if (err_count == '0) err_addr <= head.addr;
    end
  end

endmodule

// File: rtl/mem_bist.sv
// Memory BIST: writes PATTERN^addr to every word, reads back, then repeats with the inverted word.
// done after 2*(2*DEPTH+READ_LATENCY) busy cycles; start is ignored while busy, no stalls.
module mem_bist #(
  parameter int                    ADDR_WIDTH   = 4,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] PATTERN      = 8'hA5,
  parameter int                    READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  r_en,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [ADDR_WIDTH+1:0] err_count
);
  import mem_bist_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [1:0]            DRAIN_LAST = 2'(READ_LATENCY - 1);

  state_t                state, state_nxt;
  phase_t                phase;
  logic                  inv_sel;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt, addr_inc;
  logic [1:0]            drain_cnt, drain_nxt;
  logic                  w_en_nxt, r_en_nxt, busy_nxt, done_nxt, pass_nxt, fail_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt, r_addr_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt, rd_exp;
  logic                  clr, mismatch;

  function automatic logic [DATA_WIDTH-1:0] exp_of(input logic [ADDR_WIDTH-1:0] a,
                                                   input logic                  inv);
    logic [EXP_W-1:0] p_ext;
    logic [EXP_W-1:0] a_ext;
    logic [EXP_W-1:0] full;
    p_ext                 = '0;
    p_ext[DATA_WIDTH-1:0] = PATTERN;
    a_ext                 = '0;
    a_ext[ADDR_WIDTH-1:0] = a;
    full                  = exp_word(p_ext, a_ext, inv);
    return full[DATA_WIDTH-1:0];
  endfunction

  assign addr_inc = addr + ADDR_ONE;
  assign inv_sel  = (state == WR1) || (state == RD1) || (state == DRAIN1);
  assign phase    = ((state == WR0) || (state == WR1)) ? PASS_WR : PASS_RD;
  // r_en is only high in RD0/RD1, so inv_sel already names the pass of the read on the port.
  assign rd_exp   = exp_of(r_addr, inv_sel);

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    drain_nxt  = drain_cnt;
    w_en_nxt   = 1'b0;
    r_en_nxt   = 1'b0;
    w_addr_nxt = w_addr;
    w_data_nxt = w_data;
    r_addr_nxt = r_addr;
    busy_nxt   = busy;
    done_nxt   = done;
    pass_nxt   = pass;
    fail_nxt   = fail;
    clr        = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt  = WR0;
          addr_nxt   = '0;
          w_en_nxt   = 1'b1;
          w_addr_nxt = '0;
          w_data_nxt = exp_of('0, 1'b0);
          busy_nxt   = 1'b1;
          done_nxt   = 1'b0;
          pass_nxt   = 1'b0;
          fail_nxt   = 1'b0;
          clr        = 1'b1;
        end
      end
      WR0, WR1, RD0, RD1: begin
        if (addr == ADDR_LAST) begin
          addr_nxt = '0;
          if (phase == PASS_WR) begin
            state_nxt  = inv_sel ? RD1 : RD0;
            r_en_nxt   = 1'b1;
            r_addr_nxt = '0;
          end else begin
            state_nxt = inv_sel ? DRAIN1 : DRAIN0;
            drain_nxt = '0;
          end
        end else begin
          addr_nxt = addr_inc;
          if (phase == PASS_WR) begin
            w_en_nxt   = 1'b1;
            w_addr_nxt = addr_inc;
            w_data_nxt = exp_of(addr_inc, inv_sel);
          end else begin
            r_en_nxt   = 1'b1;
            r_addr_nxt = addr_inc;
          end
        end
      end
      DRAIN0, DRAIN1: begin
        if (drain_cnt == DRAIN_LAST) begin
          if (inv_sel) begin
            // The last read is compared on this same edge, so fold its result in here.
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_count == '0) && !mismatch;
            fail_nxt  = (err_count != '0) || mismatch;
          end else begin
            state_nxt  = WR1;
            addr_nxt   = '0;
            w_en_nxt   = 1'b1;
            w_addr_nxt = '0;
            w_data_nxt = exp_of('0, 1'b1);
          end
        end else begin
          drain_nxt = drain_cnt + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      drain_cnt <= '0;
      w_en      <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
      r_en      <= 1'b0;
      r_addr    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      drain_cnt <= drain_nxt;
      w_en      <= w_en_nxt;
      w_addr    <= w_addr_nxt;
      w_data    <= w_data_nxt;
      r_en      <= r_en_nxt;
      r_addr    <= r_addr_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      fail      <= fail_nxt;
    end
  end

  mem_bist_chk #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .push_vld (r_en),
    .push_dat (rd_exp),
    .push_addr(r_addr),
    .r_data   (r_data),
    .mismatch (mismatch),
    .err_addr (err_addr),
    .err_count(err_count)
  );

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: default build with fault-injecting memory, a 3-cycle-read build and a DEPTH=2 build.
// Expected write stream and per-run results are queued when a run is launched and popped as the DUT produces them.
`timescale 1ns/1ps
module tb_mem_bist;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] PAT = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   = 1'b1;
  logic start = 1'b0, start3 = 1'b0, start2 = 1'b0;
  int   cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Default build
  logic          w_en, r_en, busy, done, pass, fail;
  logic [AW-1:0] w_addr, r_addr, err_addr;
  logic [DW-1:0] w_data, r_data;
  logic [AW+1:0] err_count;

  mem_bist dut (
    .clk(clk), .rst(rst), .start(start),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .err_addr(err_addr), .err_count(err_count)
  );

  // fault: 0 clean, 1 bit0 stuck-at-1 at address 3, 2 writes ignored and reads return 0
  int            fault = 0;
  logic [DW-1:0] mem1 [DEPTH];
  always @(posedge clk) begin
    if (w_en) mem1[w_addr] <= (fault == 1 && w_addr == 4'd3) ? (w_data | 8'h01) : w_data;
    if (r_en) r_data <= (fault == 2) ? '0 : mem1[r_addr];
  end

  // READ_LATENCY=3 build with a matching three-register read path
  logic          w_en3, r_en3, busy3, done3, pass3, fail3;
  logic [AW-1:0] w_addr3, r_addr3, err_addr3;
  logic [DW-1:0] w_data3, r_data3, rd3_s1, rd3_s2;
  logic [AW+1:0] err_count3;
  logic [DW-1:0] mem3 [DEPTH];

  mem_bist #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .w_en(w_en3), .w_addr(w_addr3), .w_data(w_data3),
    .r_en(r_en3), .r_addr(r_addr3), .r_data(r_data3),
    .busy(busy3), .done(done3), .pass(pass3), .fail(fail3),
    .err_addr(err_addr3), .err_count(err_count3)
  );

  always @(posedge clk) begin
    if (w_en3) mem3[w_addr3] <= w_data3;
    rd3_s1  <= mem3[r_addr3];
    rd3_s2  <= rd3_s1;
    r_data3 <= rd3_s2;
  end

  // DEPTH=2 build
  logic          w_en2, r_en2, busy2, done2, pass2, fail2;
  logic [0:0]    w_addr2, r_addr2, err_addr2;
  logic [DW-1:0] w_data2, r_data2;
  logic [2:0]    err_count2;
  logic [DW-1:0] mem2 [2];

  mem_bist #(.ADDR_WIDTH(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .w_en(w_en2), .w_addr(w_addr2), .w_data(w_data2),
    .r_en(r_en2), .r_addr(r_addr2), .r_data(r_data2),
    .busy(busy2), .done(done2), .pass(pass2), .fail(fail2),
    .err_addr(err_addr2), .err_count(err_count2)
  );

  always @(posedge clk) begin
    if (w_en2) mem2[w_addr2] <= w_data2;
    if (r_en2) r_data2 <= mem2[r_addr2];
  end

  // Scoreboard
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  typedef struct {
    logic          p;
    logic          f;
    logic [AW-1:0] ea;
    logic [AW+1:0] ec;
    int            lat;
  } res_t;

  wr_t  wr_q [$];
  res_t res_q [$];
  wr_t  wexp;
  res_t rexp;
  int   k_start = 0;
  logic done_q  = 1'b0;
  int   wr3_cnt = 0, wr2_cnt = 0;

  function automatic logic [DW-1:0] model_exp(input int a, input int inv);
    logic [DW-1:0] v;
    v = PAT ^ DW'(a);
    if (inv != 0) v = ~v;
    return v;
  endfunction

  // Latency is counted so that start sampled at edge k and done first visible after edge k+66
  // gives 67, i.e. done "at cycle k+67".
  always @(negedge clk) begin
    check_eq("w_r_exclusive", (w_en & r_en) | (w_en3 & r_en3) | (w_en2 & r_en2), 0);
    if (w_en) begin
      check_eq("wr_expected", wr_q.size() != 0, 1);
      if (wr_q.size() != 0) begin
        wexp = wr_q.pop_front();
        check_eq("w_addr", w_addr, wexp.a);
        check_eq("w_data", w_data, wexp.d);
      end
    end
    if (w_en3) wr3_cnt++;
    if (w_en2) wr2_cnt++;
    if (done && !done_q) begin
      check_eq("res_expected", res_q.size() != 0, 1);
      if (res_q.size() != 0) begin
        rexp = res_q.pop_front();
        check_eq("pass", pass, rexp.p);
        check_eq("fail", fail, rexp.f);
        check_eq("err_addr", err_addr, rexp.ea);
        check_eq("err_count", err_count, rexp.ec);
        check_eq("done_latency", cyc - k_start + 1, rexp.lat);
      end
    end
    done_q = done;
  end

  task automatic push_writes();
    for (int pp = 0; pp < 2; pp++)
      for (int a = 0; a < DEPTH; a++)
        wr_q.push_back('{AW'(a), model_exp(a, pp)});
  endtask

  task automatic run1(input bit hold, input logic p, input logic f,
                      input logic [AW-1:0] ea, input logic [AW+1:0] ec);
    res_t r;
    push_writes();
    r = '{p, f, ea, ec, 2 * (2 * DEPTH + 1) + 1};
    res_q.push_back(r);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 k_start = cyc;
    if (!hold) start = 1'b0;
    @(negedge clk);
    check_eq("busy_after_start", busy, 1);
    check_eq("clear_on_start", {done, pass, fail, err_addr, err_count}, 0);
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    check_eq("done_seen", done, 1);
    check_eq("busy_at_done", busy, 0);
    start = 1'b0;
    @(negedge clk);
    check_eq("done_held", {done, busy}, 2'b10);
  endtask

  function automatic logic [31:0] outs1();
    return {w_en, w_addr, w_data, r_en, r_addr, busy, done, pass, fail, err_addr, err_count};
  endfunction

  int k3, k2, base;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", outs1(), 0);
    check_eq("reset_outputs3", {busy3, done3, w_en3, r_en3, err_count3}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    fault = 0;
    run1(1'b0, 1'b1, 1'b0, 4'd0, 6'd0);
    fault = 1;
    run1(1'b0, 1'b0, 1'b1, 4'd3, 6'd1);
    fault = 2;
    run1(1'b0, 1'b0, 1'b1, 4'd0, 6'd32);

    // Reset in the middle of a run, then a full clean run
    fault = 0;
    push_writes();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrun_reset_outputs", outs1(), 0);
    wr_q.delete();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle_after_reset", {busy, w_en, r_en, done}, 0);
    run1(1'b0, 1'b1, 1'b0, 4'd0, 6'd0);

    // start held through the whole run: ignored while busy, restarts only from DONE
    run1(1'b1, 1'b1, 1'b0, 4'd0, 6'd0);

    // READ_LATENCY=3 with start held high while busy
    base = wr3_cnt;
    @(posedge clk);
    #1 start3 = 1'b1;
    @(posedge clk);
    #1 k3 = cyc;
    @(negedge clk);
    check_eq("rl3_busy", busy3, 1);
    for (int i = 0; i < 200 && !done3; i++) @(negedge clk);
    start3 = 1'b0;
    check_eq("rl3_done_seen", done3, 1);
    check_eq("rl3_latency", cyc - k3 + 1, 71);
    check_eq("rl3_result", {pass3, fail3, err_count3}, {1'b1, 1'b0, 6'd0});
    check_eq("rl3_writes", wr3_cnt - base, 32);
    @(negedge clk);
    check_eq("rl3_done_held", {done3, busy3}, 2'b10);

    // DEPTH=2
    base = wr2_cnt;
    @(posedge clk);
    #1 start2 = 1'b1;
    @(posedge clk);
    #1 k2 = cyc;
    start2 = 1'b0;
    for (int i = 0; i < 100 && !done2; i++) @(negedge clk);
    check_eq("d2_done_seen", done2, 1);
    check_eq("d2_latency", cyc - k2 + 1, 11);
    check_eq("d2_result", {pass2, fail2, err_count2}, {1'b1, 1'b0, 3'd0});
    check_eq("d2_writes", wr2_cnt - base, 4);

    check_eq("wr_q_drained", wr_q.size(), 0);
    check_eq("res_q_drained", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
